pixel_write_receiver: RTL and testbench

- Receiving end of the (x, y, colour, plot) pixel-write interface that our drawing datapaths drive every cycle.
- Clips, buffers and converts pixel coordinates into linear framebuffer write cycles for the 320x240, 3-bit-colour video memory write port.
- Also provides a hardware clear-screen fill, used when switching scenes without redrawing every pixel from ROM.

---
 rtl/pixel_write_receiver.sv | 191 +++++++++++++++++++
 tb/tb_pixel_write_receiver.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_receiver.sv
// Pixel-write sink: clips and buffers (x, y, colour) writes, converts them to linear
// framebuffer write cycles, and provides a whole-frame clear fill.
module pixel_write_receiver #(
    parameter int unsigned WIDTH       = 320,
    parameter int unsigned HEIGHT      = 240,
    parameter int unsigned COLOUR_BITS = 3,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ADDR_W      = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8:0]             x,
    input  logic [7:0]             y,
    input  logic [COLOUR_BITS-1:0] colour,
    input  logic                   plot,
    input  logic                   clear_req,
    input  logic [COLOUR_BITS-1:0] clear_colour,
    output logic                   busy,
    output logic                   full,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [COLOUR_BITS-1:0] mem_data,
    output logic                   mem_we,
    output logic [15:0]            clip_count,
    output logic [15:0]            drop_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [8:0]        X_LIM     = 9'(WIDTH);
    localparam logic [7:0]        Y_LIM     = 8'(HEIGHT);
    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [0:0] {StStream, StClear} state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   full_q, full_d;
    logic                   busy_q, busy_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [COLOUR_BITS-1:0] mem_data_q, mem_data_d;
    logic                   mem_we_q, mem_we_d;
    logic [15:0]            clip_q, clip_d;
    logic [15:0]            drop_q, drop_d;
    logic [ADDR_W-1:0]      fill_cnt_q, fill_cnt_d;
    logic [COLOUR_BITS-1:0] fill_col_q, fill_col_d;

    logic [8:0]             fifo_x_q [FIFO_DEPTH];
    logic [7:0]             fifo_y_q [FIFO_DEPTH];
    logic [COLOUR_BITS-1:0] fifo_c_q [FIFO_DEPTH];

    logic                   in_range;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic [ADDR_W-1:0]      head_x_w;
    logic [ADDR_W-1:0]      head_y_w;
    logic [ADDR_W-1:0]      head_addr;

    always_comb begin
        in_range   = (x < X_LIM) && (y < Y_LIM);
        fifo_full  = (count_q == DEPTH_C);
        fifo_empty = (count_q == '0);
        push       = plot && in_range && !fifo_full;
        // The clear_req edge never pops, so the fill is not interleaved with a drain.
        pop        = (state_q == StStream) && !clear_req && !fifo_empty;

        head_x_w = ADDR_W'(fifo_x_q[rd_ptr_q]);
        head_y_w = ADDR_W'(fifo_y_q[rd_ptr_q]);
        if (WIDTH == 320) begin
            head_addr = (head_y_w << 8) + (head_y_w << 6) + head_x_w;
        end else begin
            head_addr = ADDR_W'(head_y_w * ADDR_W'(WIDTH)) + head_x_w;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        fill_cnt_d = fill_cnt_q;
        fill_col_d = fill_col_q;

        case (state_q)
            StStream: begin
                busy_d = clear_req;
                if (pop) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = head_addr;
                    mem_data_d = fifo_c_q[rd_ptr_q];
                end
                if (clear_req) begin
                    state_d    = StClear;
                    fill_cnt_d = '0;
                    fill_col_d = clear_colour;
                end
            end
            StClear: begin
                // busy stays high through the final fill write's cycle.
                busy_d     = 1'b1;
                mem_we_d   = 1'b1;
                mem_addr_d = fill_cnt_q;
                mem_data_d = fill_col_q;
                if (fill_cnt_q == FILL_LAST) begin
                    state_d = StStream;
                end else begin
                    fill_cnt_d = fill_cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = StStream;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == DEPTH_C);

        clip_d = clip_q;
        if (plot && !in_range && (clip_q != 16'hFFFF)) begin
            clip_d = clip_q + 16'd1;
        end
        drop_d = drop_q;
        if (plot && in_range && fifo_full && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StStream;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            clip_q     <= '0;
            drop_q     <= '0;
            fill_cnt_q <= '0;
            fill_col_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            busy_q     <= busy_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            clip_q     <= clip_d;
            drop_q     <= drop_d;
            fill_cnt_q <= fill_cnt_d;
            fill_col_q <= fill_col_d;
        end
    end

    // Entry storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x_q[wr_ptr_q] <= x;
            fifo_y_q[wr_ptr_q] <= y;
            fifo_c_q[wr_ptr_q] <= colour;
        end
    end

    assign busy       = busy_q;
    assign full       = full_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_we     = mem_we_q;
    assign clip_count = clip_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_pixel_write_receiver.sv
// Directed self-checking bench for pixel_write_receiver.
module tb_pixel_write_receiver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  px = '0;
    logic [7:0]  py = '0;
    logic [2:0]  pc = '0;
    logic        plot = 1'b0;
    logic        clear_req = 1'b0;
    logic [2:0]  clear_colour = '0;
    logic        busy;
    logic        full;
    logic [16:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic [15:0] clip_count;
    logic [15:0] drop_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [16:0] wa[$];
    logic [2:0]  wd[$];
    int          wc[$];
    logic        full_seen;

    pixel_write_receiver dut (
        .clk          (clk),
        .reset        (reset),
        .x            (px),
        .y            (py),
        .colour       (pc),
        .plot         (plot),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .busy         (busy),
        .full         (full),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .clip_count   (clip_count),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_rec();
        step();
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
            wc.push_back(cyc);
        end
        if (full) full_seen = 1'b1;
    endtask

    task automatic rec_clear();
        wa.delete();
        wd.delete();
        wc.delete();
        full_seen = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        total++;
        if ({busy, full, mem_we} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags busy/full/we=%b%b%b want 000", busy, full, mem_we);
        end
        total++;
        if (mem_addr !== 17'd0 || mem_data !== 3'd0) begin
            bad++;
            $display("FAIL reset_mem addr=%0d data=%0d want 0 0", mem_addr, mem_data);
        end
        total++;
        if (clip_count !== 16'd0 || drop_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_counts clip=%0d drop=%0d want 0 0", clip_count, drop_count);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        plot = 1'b1; px = 9'd5; py = 8'd2; pc = 3'b101;
        step();
        plot = 1'b0;
        total++;
        if (mem_we !== 1'b0) begin
            bad++;
            $display("FAIL single_early we=%b want 0", mem_we);
        end
        step();
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 17'd645 || mem_data !== 3'd5) begin
            bad++;
            $display("FAIL single_write we=%b addr=%0d data=%0d want 1 645 5",
                     mem_we, mem_addr, mem_data);
        end
        step();
        total++;
        if (mem_we !== 1'b0) begin
            bad++;
            $display("FAIL single_after we=%b want 0", mem_we);
        end
    endtask

    task automatic test_corners();
        rec_clear();
        plot = 1'b1; px = 9'd0;   py = 8'd0;   pc = 3'd3; step_rec();
        px = 9'd319; py = 8'd239; pc = 3'd6;             step_rec();
        px = 9'd320; py = 8'd0;   pc = 3'd1;             step_rec();
        px = 9'd0;   py = 8'd240; pc = 3'd1;             step_rec();
        plot = 1'b0;
        repeat (6) step_rec();
        total++;
        if (wa.size() !== 2) begin
            bad++;
            $display("FAIL corner_nwrites got=%0d want 2", wa.size());
        end else begin
            total++;
            if (wa[0] !== 17'd0 || wd[0] !== 3'd3) begin
                bad++;
                $display("FAIL corner_origin addr=%0d data=%0d want 0 3", wa[0], wd[0]);
            end
            total++;
            if (wa[1] !== 17'd76799 || wd[1] !== 3'd6) begin
                bad++;
                $display("FAIL corner_last addr=%0d data=%0d want 76799 6", wa[1], wd[1]);
            end
        end
        total++;
        if (clip_count !== 16'd2) begin
            bad++;
            $display("FAIL corner_clip got=%0d want 2", clip_count);
        end
    endtask

    task automatic test_burst();
        logic [16:0] ea;
        rec_clear();
        for (int i = 0; i < 10; i++) begin
            plot = 1'b1; px = 9'(10 + i); py = 8'(i); pc = 3'(i);
            step_rec();
        end
        plot = 1'b0;
        repeat (4) step_rec();
        total++;
        if (wa.size() !== 10) begin
            bad++;
            $display("FAIL burst_nwrites got=%0d want 10", wa.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                ea = 17'(i * 320 + 10 + i);
                total++;
                if (wa[i] !== ea || wd[i] !== 3'(i) || wc[i] !== wc[0] + i) begin
                    bad++;
                    $display("FAIL burst_w%0d addr=%0d data=%0d cyc=%0d want %0d %0d %0d",
                             i, wa[i], wd[i], wc[i], ea, i % 8, wc[0] + i);
                end
            end
        end
        total++;
        if (full_seen !== 1'b0 || drop_count !== 16'd0) begin
            bad++;
            $display("FAIL burst_nofull full_seen=%b drop=%0d want 0 0", full_seen, drop_count);
        end
    endtask

    task automatic test_clear();
        int fill_err = 0;
        int first_bad = -1;
        clear_req = 1'b1; clear_colour = 3'b010;
        step();
        clear_req = 1'b0; clear_colour = 3'b000;
        total++;
        if (busy !== 1'b1 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL clear_start busy=%b we=%b want 1 0", busy, mem_we);
        end
        for (int k = 0; k < 76800; k++) begin
            if (k >= 100 && k <= 105) begin
                plot = 1'b1; px = 9'(k - 100); py = 8'd5; pc = 3'(k - 99);
            end else begin
                plot = 1'b0;
            end
            step();
            if (mem_we !== 1'b1 || mem_addr !== 17'(k) || mem_data !== 3'd2 || busy !== 1'b1)
            begin
                fill_err++;
                if (first_bad < 0) first_bad = k;
            end
            if (k == 103) begin
                total++;
                if (full !== 1'b1) begin
                    bad++;
                    $display("FAIL clear_full got=%b want 1", full);
                end
            end
        end
        total++;
        if (fill_err != 0) begin
            bad++;
            $display("FAIL clear_fill errors=%0d first_at=%0d want 0", fill_err, first_bad);
        end
        total++;
        if (drop_count !== 16'd2 || clip_count !== 16'd2) begin
            bad++;
            $display("FAIL clear_counts drop=%0d clip=%0d want 2 2", drop_count, clip_count);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (mem_we !== 1'b1 || mem_addr !== 17'(1600 + i) || mem_data !== 3'(i + 1) ||
                busy !== 1'b0) begin
                bad++;
                $display("FAIL drain_w%0d we=%b addr=%0d data=%0d busy=%b want 1 %0d %0d 0",
                         i, mem_we, mem_addr, mem_data, busy, 1600 + i, i + 1);
            end
        end
        step();
        total++;
        if (mem_we !== 1'b0 || full !== 1'b0) begin
            bad++;
            $display("FAIL drain_end we=%b full=%b want 0 0", mem_we, full);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n = 0;
        clear_req = 1'b1; clear_colour = 3'b111;
        step();
        clear_req = 1'b0;
        while (!(mem_we === 1'b1 && mem_addr === 17'd1000) && n < 2000) begin
            step();
            n++;
        end
        total++;
        if (n >= 2000) begin
            bad++;
            $display("FAIL midclear_reach timed out addr=%0d want 1000", mem_addr);
        end
        reset = 1'b1;
        #1;
        total++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || full !== 1'b0) begin
            bad++;
            $display("FAIL midclear_reset we=%b busy=%b full=%b want 0 0 0", mem_we, busy, full);
        end
        total++;
        if (clip_count !== 16'd0 || drop_count !== 16'd0 || mem_addr !== 17'd0) begin
            bad++;
            $display("FAIL midclear_counts clip=%0d drop=%0d addr=%0d want 0 0 0",
                     clip_count, drop_count, mem_addr);
        end
        step();
        step();
        reset = 1'b0;
        rec_clear();
        repeat (3) step_rec();
        plot = 1'b1; px = 9'd1; py = 8'd0; pc = 3'd6;
        step_rec();
        plot = 1'b0;
        repeat (5) step_rec();
        total++;
        if (wa.size() !== 1) begin
            bad++;
            $display("FAIL postreset_nwrites got=%0d want 1", wa.size());
        end else begin
            total++;
            if (wa[0] !== 17'd1 || wd[0] !== 3'd6) begin
                bad++;
                $display("FAIL postreset_write addr=%0d data=%0d want 1 6", wa[0], wd[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_corners();
        test_burst();
        test_clear();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
